// File: rtl/axis_stream_checker_if.sv
// AXI-Stream handshake/data bundle between a stream source and axis_stream_checker.
interface axis_stream_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tstrb, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks an incrementing data pattern and reports pass/fail.
// Optional macro AXIS_CHECKER_THROTTLE_EN adds LFSR-driven backpressure on tready.
module axis_stream_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    PKT_LEN    = 16,
    parameter int                    NUM_PKTS   = 4,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] SEED       = '0
) (
    input  logic                   s01_axis_aclk,
    input  logic                   s01_axis_areset,
    axis_stream_checker_if.slave   s01_axis,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_WIDTH-1:0]   beat_count,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic                   first_err_valid,
    output logic [DATA_WIDTH-1:0]  first_err_expected,
    output logic [DATA_WIDTH-1:0]  first_err_received
);
    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q;
    logic                  busy_q, done_q, pass_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_WIDTH-1:0]  beat_q, pkt_q, err_q;
    logic                  fev_q;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_rcv_q;

    logic                  acc, last_pos, beat_err, final_beat;
    logic [CNT_WIDTH-1:0]  err_d;

`ifdef AXIS_CHECKER_THROTTLE_EN
    logic [7:0] lfsr_q;

    // x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0
    always_ff @(posedge s01_axis_aclk or posedge s01_axis_areset) begin
        if (s01_axis_areset)     lfsr_q <= 8'hA5;
        else if (start)          lfsr_q <= 8'hA5;
        else if (state_q == RUN) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign s01_axis.tready = (state_q == RUN) & lfsr_q[0];
`else
    assign s01_axis.tready = (state_q == RUN);
`endif

    assign acc        = s01_axis.tvalid & s01_axis.tready;
    assign last_pos   = (idx_q == IDX_W'(PKT_LEN - 1));
    assign beat_err   = (s01_axis.tdata != exp_q) | ~(&s01_axis.tstrb) | (s01_axis.tlast != last_pos);
    assign final_beat = last_pos & (pkt_q == CNT_WIDTH'(NUM_PKTS - 1));
    assign err_d      = (&err_q) ? err_q : err_q + 1'b1;

    // start has priority over any beat presented on the same edge
    always_ff @(posedge s01_axis_aclk or posedge s01_axis_areset) begin
        if (s01_axis_areset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            exp_q    <= SEED;
            idx_q    <= '0;
            beat_q   <= '0;
            pkt_q    <= '0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fe_exp_q <= '0;
            fe_rcv_q <= '0;
        end else if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            exp_q    <= SEED;
            idx_q    <= '0;
            beat_q   <= '0;
            pkt_q    <= '0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fe_exp_q <= '0;
            fe_rcv_q <= '0;
        end else if (state_q == RUN && acc) begin
            exp_q  <= exp_q + 1'b1;
            beat_q <= beat_q + 1'b1;
            idx_q  <= last_pos ? '0 : idx_q + 1'b1;
            if (last_pos) pkt_q <= pkt_q + 1'b1;
            if (beat_err) begin
                err_q <= err_d;
                if (!fev_q) begin
                    fev_q    <= 1'b1;
                    fe_exp_q <= exp_q;
                    fe_rcv_q <= s01_axis.tdata;
                end
            end
            if (final_beat) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= !beat_err && (err_q == '0);
            end
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign beat_count         = beat_q;
    assign pkt_count          = pkt_q;
    assign err_count          = err_q;
    assign first_err_valid    = fev_q;
    assign first_err_expected = fe_exp_q;
    assign first_err_received = fe_rcv_q;
endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed bench: two checker instances (seed 0 / two packets, seed FFFFFFFE / one packet).
module tb_axis_stream_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    int   ncmp = 0, nerr = 0;

    always #5 clk = ~clk;

    axis_stream_checker_if #(.DATA_WIDTH(32)) if_a ();
    axis_stream_checker_if #(.DATA_WIDTH(32)) if_b ();

    logic        busy_a, done_a, pass_a, fev_a;
    logic [15:0] beat_a, pkt_a, err_a;
    logic [31:0] fexp_a, frcv_a;
    logic        busy_b, done_b, pass_b, fev_b;
    logic [15:0] beat_b, pkt_b, err_b;
    logic [31:0] fexp_b, frcv_b;

    axis_stream_checker #(.DATA_WIDTH(32), .PKT_LEN(4), .NUM_PKTS(2), .CNT_WIDTH(16), .SEED(32'h0)) dut_a (
        .s01_axis_aclk(clk), .s01_axis_areset(rst), .s01_axis(if_a), .start(start_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .beat_count(beat_a), .pkt_count(pkt_a),
        .err_count(err_a), .first_err_valid(fev_a), .first_err_expected(fexp_a),
        .first_err_received(frcv_a));

    axis_stream_checker #(.DATA_WIDTH(32), .PKT_LEN(4), .NUM_PKTS(1), .CNT_WIDTH(16), .SEED(32'hFFFF_FFFE)) dut_b (
        .s01_axis_aclk(clk), .s01_axis_areset(rst), .s01_axis(if_b), .start(start_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .beat_count(beat_b), .pkt_count(pkt_b),
        .err_count(err_b), .first_err_valid(fev_b), .first_err_expected(fexp_b),
        .first_err_received(frcv_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the beat until accepted, returns at the negedge after.
    task automatic send(input bit b, input logic [31:0] d, input logic l, input logic [3:0] s);
        int   n = 0;
        logic rdy;
        if (b) begin if_b.tdata = d; if_b.tlast = l; if_b.tstrb = s; if_b.tvalid = 1'b1; end
        else   begin if_a.tdata = d; if_a.tlast = l; if_a.tstrb = s; if_a.tvalid = 1'b1; end
        rdy = b ? if_b.tready : if_a.tready;
        while (!rdy && n < 64) begin
            @(negedge clk);
            n++;
            rdy = b ? if_b.tready : if_a.tready;
        end
        check("send_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (b) if_b.tvalid = 1'b0; else if_a.tvalid = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

`ifdef AXIS_CHECKER_THROTTLE_EN
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction
`endif

    initial begin
        if_a.tvalid = 1'b0; if_a.tdata = '0; if_a.tlast = 1'b0; if_a.tstrb = 4'hF;
        if_b.tvalid = 1'b0; if_b.tdata = '0; if_b.tlast = 1'b0; if_b.tstrb = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_tready", 32'(if_a.tready), 0);
        check("rst_busy",   32'(busy_a), 0);
        check("rst_done",   32'(done_a), 0);
        check("rst_pass",   32'(pass_a), 0);
        check("rst_beat",   32'(beat_a), 0);
        check("rst_fev",    32'(fev_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean two-packet run
        pulse_start_a();
        check("run_busy",   32'(busy_a), 1);
        check("run_tready", 32'(if_a.tready), 1);
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 32'(i), (i % 4) == 3, 4'hF);
            if (i == 3) begin
                check("mid_pkt",  32'(pkt_a), 1);
                check("mid_beat", 32'(beat_a), 4);
            end
        end
        check("clean_done",   32'(done_a), 1);
        check("clean_pass",   32'(pass_a), 1);
        check("clean_err",    32'(err_a), 0);
        check("clean_pkt",    32'(pkt_a), 2);
        check("clean_beat",   32'(beat_a), 8);
        check("clean_tready", 32'(if_a.tready), 0);
        check("clean_busy",   32'(busy_a), 0);

        // Restart in RUN with a simultaneous (bad) beat: start wins, beat discarded
        pulse_start_a();
        check("st_clear_done", 32'(done_a), 0);
        check("st_clear_beat", 32'(beat_a), 0);
        start_a = 1'b1;
        if_a.tvalid = 1'b1; if_a.tdata = 32'h77; if_a.tlast = 1'b1; if_a.tstrb = 4'hF;
        @(negedge clk);
        start_a = 1'b0; if_a.tvalid = 1'b0;
        check("st_hs_beat", 32'(beat_a), 0);
        check("st_hs_err",  32'(err_a), 0);
        check("st_hs_busy", 32'(busy_a), 1);

        // Data error on beat 5
        for (int i = 0; i < 8; i++) begin
            send(1'b0, (i == 5) ? 32'hDEAD : 32'(i), (i % 4) == 3, 4'hF);
            if (i == 5) begin
                check("dead_err", 32'(err_a), 1);
                check("dead_fev", 32'(fev_a), 1);
                check("dead_fexp", fexp_a, 32'd5);
                check("dead_frcv", frcv_a, 32'hDEAD);
            end
        end
        check("dead_err_end",  32'(err_a), 1);
        check("dead_fexp_end", fexp_a, 32'd5);
        check("dead_pass",     32'(pass_a), 0);
        check("dead_done",     32'(done_a), 1);

        // Framing and strobe errors
        pulse_start_a();
        check("fr_fev_clear", 32'(fev_a), 0);
        for (int i = 0; i < 8; i++)
            send(1'b0, 32'(i), (i == 5) || (i == 7), (i == 6) ? 4'b0111 : 4'hF);
        check("fr_err",  32'(err_a), 3);
        check("fr_pkt",  32'(pkt_a), 2);
        check("fr_fexp", fexp_a, 32'd3);
        check("fr_frcv", frcv_a, 32'd3);
        check("fr_pass", 32'(pass_a), 0);
        check("fr_done", 32'(done_a), 1);

        // Expected value wraps across 2^32, tvalid gaps between beats
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        send(1'b1, 32'hFFFF_FFFE, 1'b0, 4'hF); repeat (2) @(negedge clk);
        send(1'b1, 32'hFFFF_FFFF, 1'b0, 4'hF); repeat (3) @(negedge clk);
        send(1'b1, 32'h0000_0000, 1'b0, 4'hF); @(negedge clk);
        send(1'b1, 32'h0000_0001, 1'b1, 4'hF);
        check("wrap_pass", 32'(pass_b), 1);
        check("wrap_beat", 32'(beat_b), 4);
        check("wrap_err",  32'(err_b), 0);
        check("wrap_done", 32'(done_b), 1);

        // Asynchronous reset mid-run
        pulse_start_a();
        for (int i = 0; i < 3; i++) send(1'b0, 32'(i), 1'b0, 4'hF);
        check("pre_rst_beat", 32'(beat_a), 3);
        rst = 1'b1;
        #1;
        check("ar_tready", 32'(if_a.tready), 0);
        check("ar_busy",   32'(busy_a), 0);
        check("ar_done",   32'(done_a), 0);
        check("ar_pass",   32'(pass_a), 0);
        check("ar_beat",   32'(beat_a), 0);
        check("ar_pkt",    32'(pkt_a), 0);
        check("ar_err",    32'(err_a), 0);
        check("ar_fev",    32'(fev_a), 0);
        check("ar_fexp",   fexp_a, 0);
        check("ar_frcv",   frcv_a, 0);
        check("ar_pass_b", 32'(pass_b), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy_a), 0);
        pulse_start_a();
        for (int i = 0; i < 8; i++) send(1'b0, 32'(i), (i % 4) == 3, 4'hF);
        check("post_rst_pass", 32'(pass_a), 1);
        check("post_rst_beat", 32'(beat_a), 8);

`ifdef AXIS_CHECKER_THROTTLE_EN
        begin
            logic [7:0] r;
            int         nb, cyc;
            pulse_start_a();
            r = 8'hA5; nb = 0; cyc = 0;
            if_a.tvalid = 1'b1; if_a.tstrb = 4'hF;
            while (nb < 8 && cyc < 200) begin
                if_a.tdata = 32'(nb);
                if_a.tlast = (nb % 4) == 3;
                check("thr_tready", 32'(if_a.tready), 32'(r[0]));
                if (if_a.tready) nb++;
                @(negedge clk);
                r = lfsr_step(r);
                cyc++;
            end
            if_a.tvalid = 1'b0;
            check("thr_beats", 32'(nb), 8);
            check("thr_pass",  32'(pass_a), 1);
            check("thr_beat",  32'(beat_a), 8);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/axis_stream_checker.md
# axis_stream_checker

Downstream AXI-Stream sink that consumes the read-out stream of `memory_controller` (its `m01_axis_*` master port) and checks it against an expected incrementing pattern. It tracks beats, packets and errors, captures the first mismatch, and reports pass/fail once a programmed number of packets has been received. It closes the write-then-read loop in lab benches and on-board self-test.

## Interface
- `DATA_WIDTH`, 32: stream data width; must be a multiple of 8.
- `PKT_LEN`, 16: beats per packet, ≥ 1.
- `NUM_PKTS`, 4: packets to check before done, ≥ 1.
- `CNT_WIDTH`, 16: width of all counters.
- `SEED`, 0: expected value of the first beat after start.

- `s01_axis_aclk`  in  1  single clock; all logic on rising edge.
- `s01_axis_areset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; clears status and begins a check run.
- `s01_axis_tdata`  in  DATA_WIDTH  received data.
- `s01_axis_tstrb`  in  DATA_WIDTH/8  byte strobes; all ones required.
- `s01_axis_tvalid`  in  1  upstream data valid.
- `s01_axis_tlast`  in  1  upstream end-of-packet.
- `s01_axis_tready`  out  1  checker accepts a beat.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  done and err_count == 0.
- `beat_count`  out  CNT_WIDTH  accepted beats this run.
- `pkt_count`  out  CNT_WIDTH  completed packets this run.
- `err_count`  out  CNT_WIDTH  erroneous beats, saturating.
- `first_err_valid`  out  1  first-error capture registers hold data.
- `first_err_expected`  out  DATA_WIDTH  expected value at the first error.
- `first_err_received`  out  DATA_WIDTH  received tdata at the first error.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when the beat that completes packet NUM_PKTS is accepted.
  - DONE→RUN on `start`.
  - `start` in RUN restarts the run.
- On `start`:
  - expected ← SEED; beat index ← 0.
  - All counters, `first_err_*` and `pass` are cleared.
- A beat is accepted on a rising edge when `tvalid & tready`. Nothing changes on edges without a handshake.
- Per accepted beat, an error is any of:
  - `tdata != expected`;
  - `tstrb` not all ones;
  - `tlast` high while beat index != PKT_LEN-1;
  - `tlast` low while beat index == PKT_LEN-1.
- Any error on a beat increments `err_count` by exactly 1. `err_count` saturates at all ones.
- First error only: latch `first_err_expected`/`first_err_received` and set `first_err_valid`. Later errors do not overwrite the capture.
- `expected` increments by 1 per accepted beat, modulo 2^DATA_WIDTH, continuously across packets. It never resyncs to received data.
- Packet framing is positional:
  - Beat index wraps to 0 after PKT_LEN-1.
  - `pkt_count` increments at that wrap, regardless of `tlast`.
- `beat_count` and `pkt_count` wrap modulo 2^CNT_WIDTH.

## Timing
- Reset values:
  - `tready`, `busy`, `done`, `pass`, `first_err_valid` = 0.
  - All counters = 0; `first_err_*` data = 0.
  - State = IDLE.
- Reset takes effect immediately, mid-run included. No beat is accepted while reset is high.
- `start` sampled at edge N: `busy` and `tready` are high from cycle N+1.
- Counters and capture registers update on the accepting edge and are visible the next cycle.
- Final beat accepted at edge M: `done` and `pass` are valid and `tready` is low from cycle M+1.
- `tready` is driven from registered state only and never depends on `tvalid`.
- Simultaneous `start` and handshake: the beat is discarded and `start` wins.

## Configuration
- `AXIS_CHECKER_THROTTLE_EN` defined:
  - Adds an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 on reset and on `start`, stepping every cycle in RUN.
  - `tready = RUN & lfsr[0]`, which applies pseudo-random backpressure.
- Undefined: `tready = RUN`. No LFSR logic is present.

## Test plan
- PKT_LEN=4, NUM_PKTS=2, SEED=0; send 0..7 with `tlast` on beats 3 and 7:
  - `done`=1, `pass`=1, `err_count`=0, `pkt_count`=2, `beat_count`=8, `tready`=0 the cycle after beat 7.
- Same config, beat 5 sent as 32'hDEAD:
  - `err_count`=1, `first_err_expected`=5, `first_err_received`=32'hDEAD, `pass`=0.
  - Beats 6 and 7 are still checked against 6 and 7 with no extra errors.
- `tlast` missing on beat 3 and asserted on beat 5; `tstrb`=4'b0111 on beat 6:
  - `err_count`=3.
  - `pkt_count`=2 (positional framing).
- SEED=32'hFFFF_FFFE, PKT_LEN=4, NUM_PKTS=1; send FFFFFFFE, FFFFFFFF, 0, 1 with `tvalid` gaps between beats:
  - `pass`=1, `beat_count`=4.
- Assert `s01_axis_areset` after 3 accepted beats:
  - All outputs read 0 in the same cycle.
  - `start` then a clean 8-beat stream gives `pass`=1.
- With `AXIS_CHECKER_THROTTLE_EN` defined and `tvalid` held high:
  - `tready` matches the reference LFSR sequence from seed A5.
  - All 8 beats are accepted in order and `pass`=1.
